flash_loader: RTL

- SPI read master that copies a block of 32-bit words from the external serial flash (P25Q32U, read command 0x03) into on-chip RAM through a simple write port.
- Sits between the flash pins and the RAM/cache write path; the boot sequencer pulses start once after reset to load the program image.
- Sequences the flash transaction: chip select, command byte, 24-bit address, then streaming data with flow control.

---
 rtl/flash_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flash_loader.sv
// SPI mode-0 read master: streams 32-bit little-endian words from a serial flash
// (single READ command, auto-incrementing address) into a RAM write port.
module flash_loader #(
    parameter int          RamAddressBitWidth = 16,
    parameter logic [7:0]  ReadCommand        = 8'h03
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [23:0]                   flash_address,
    input  logic [RamAddressBitWidth-1:0] ram_base,
    input  logic [15:0]                   word_count,
    output logic                          busy,
    output logic                          done,
    output logic                          spi_cs_n,
    output logic                          spi_sck,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic                          wr_enable,
    output logic [RamAddressBitWidth-1:0] wr_address,
    output logic [31:0]                   wr_data,
    input  logic                          wr_ready
);

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        WRITE,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        lead;
    logic        phase;
    logic [4:0]  bit_cnt;
    logic [4:0]  last_bit;
    logic [31:0] shift_out;
    logic [31:0] rx;
    logic [31:0] rx_next;
    logic [15:0] remaining;
    logic        shifting;
    logic        bit_end;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign shifting = (state == COMMAND) || (state == ADDRESS) || (state == DATA);
    // A bit completes on the edge that ends its high phase.
    assign bit_end  = shifting && !lead && phase;
    assign rx_next  = {rx[30:0], spi_miso};

    always_comb begin
        case (state)
            COMMAND: last_bit = 5'd7;
            ADDRESS: last_bit = 5'd23;
            default: last_bit = 5'd31;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        spi_cs_n   = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        wr_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == 16'd0) ? FINISH : COMMAND;
                end
            end
            COMMAND, ADDRESS: begin
                busy     = 1'b1;
                spi_cs_n = 1'b0;
                spi_sck  = phase;
                spi_mosi = shift_out[31];
                if (bit_end && bit_cnt == last_bit) begin
                    state_next = (state == COMMAND) ? ADDRESS : DATA;
                end
            end
            DATA: begin
                busy     = 1'b1;
                spi_cs_n = 1'b0;
                spi_sck  = phase;
                if (bit_end && bit_cnt == last_bit) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                spi_cs_n  = 1'b0;
                wr_enable = 1'b1;
                if (wr_ready) begin
                    state_next = (remaining == 16'd1) ? FINISH : DATA;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the lead cycle after chip select gives the flash CS setup time
    // before the first clock edge; command and address share one 32-bit shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lead       <= 1'b0;
            phase      <= 1'b0;
            bit_cnt    <= 5'd0;
            shift_out  <= 32'd0;
            rx         <= 32'd0;
            remaining  <= 16'd0;
            wr_address <= '0;
            wr_data    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && word_count != 16'd0) begin
                        shift_out  <= {ReadCommand, flash_address};
                        wr_address <= ram_base;
                        remaining  <= word_count;
                        lead       <= 1'b1;
                        phase      <= 1'b0;
                        bit_cnt    <= 5'd0;
                    end
                end
                COMMAND, ADDRESS, DATA: begin
                    if (lead) begin
                        lead <= 1'b0;
                    end else begin
                        phase <= ~phase;
                        if (phase) begin
                            bit_cnt <= (bit_cnt == last_bit) ? 5'd0 : bit_cnt + 1'b1;
                            if (state == DATA) begin
                                rx <= rx_next;
                                if (bit_cnt == last_bit) begin
                                    wr_data <= byte_swap(rx_next);
                                end
                            end else begin
                                shift_out <= shift_out << 1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_address <= wr_address + 1'b1;
                        remaining  <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
